cam_fb_writer: RTL and testbench

- Downstream of the camera capture stage, on the same pixel clock.
- Consumes the 24-bit RGB pixel stream (`pixel_data`/`pixel_valid`) and the `frame_done` flag.
- On a CPU arm request it grabs exactly one whole frame: each pixel is packed to RGB332 and written sequentially into the frame-buffer RAM.
- Reports busy/done/overflow and the pixel count to the J1 register interface.

---
 rtl/cam_fb_writer.sv | 139 +++++++++++++
 tb/tb_cam_fb_writer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_fb_writer.sv
// Grabs one whole camera frame per arm request and writes it as RGB332 into the frame buffer.
// Write strobe one cycle after pixel acceptance. Define CAM_FB_DOUBLE_BUF_EN for ping-pong banks.
module cam_fb_writer #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              p_clock,
  input  logic              rst,
  input  logic              arm,
  input  logic [23:0]       pixel_data,
  input  logic              pixel_valid,
  input  logic              frame_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   pix_count
`ifdef CAM_FB_DOUBLE_BUF_EN
  ,
  output logic              fb_bank
`endif
);

  localparam int FRAME = H_RES * V_RES;
  localparam logic [ADDR_W:0] FRAME_N = (ADDR_W + 1)'(FRAME);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic              fd_q;
  logic              fd_rise;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   cnt_d;
  logic              ovf_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        wdata_d;
  logic [ADDR_W:0]   addr_full;
  logic [7:0]        packed_px;
  logic              unused_bits;
`ifdef CAM_FB_DOUBLE_BUF_EN
  logic              bank_d;
`endif

  assign fd_rise   = frame_done & ~fd_q;
  assign packed_px = {pixel_data[7:5], pixel_data[15:13], pixel_data[23:22]};
  assign busy      = (state_q == ARMED) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);

`ifdef CAM_FB_DOUBLE_BUF_EN
  // Capture always fills the bank that is not being displayed.
  assign addr_full = (fb_bank ? '0 : FRAME_N) + idx_q;
`else
  assign addr_full = idx_q;
`endif

  assign unused_bits = ^{pixel_data[4:0], pixel_data[12:8], pixel_data[21:16], addr_full[ADDR_W]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = pix_count;
    ovf_d   = overflow;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
`ifdef CAM_FB_DOUBLE_BUF_EN
    bank_d  = fb_bank;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        // Wait for a frame boundary so a partial frame is never stored.
        if (fd_rise) begin
          idx_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (pixel_valid) begin
          if (idx_q < FRAME_N) begin
            we_d    = 1'b1;
            addr_d  = addr_full[ADDR_W-1:0];
            wdata_d = packed_px;
            idx_d   = idx_q + 1'b1;
            cnt_d   = pix_count + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (fd_rise) begin
          state_d = DONE;
`ifdef CAM_FB_DOUBLE_BUF_EN
          if (cnt_d == FRAME_N) bank_d = ~fb_bank;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_clock) begin
    if (rst) begin
      state_q   <= IDLE;
      fd_q      <= 1'b0;
      idx_q     <= '0;
      pix_count <= '0;
      overflow  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef CAM_FB_DOUBLE_BUF_EN
      fb_bank   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      fd_q      <= frame_done;
      idx_q     <= idx_d;
      pix_count <= cnt_d;
      overflow  <= ovf_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
`ifdef CAM_FB_DOUBLE_BUF_EN
      fb_bank   <= bank_d;
`endif
    end
  end

endmodule

// File: tb/tb_cam_fb_writer.sv
// Bench for cam_fb_writer with a 4x2 frame; honours CAM_FB_DOUBLE_BUF_EN when defined.
module tb_cam_fb_writer;
  localparam int H = 4, V = 2, AW = 4, FRAME = H * V;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;
`ifdef CAM_FB_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          p_clock = 1'b0;
  logic          rst, arm, pixel_valid, frame_done;
  logic [23:0]   pixel_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy, done, overflow;
  logic [AW:0]   pix_count;
  logic          fb_bank;
`ifndef CAM_FB_DOUBLE_BUF_EN
  assign fb_bank = 1'b0;
`endif

  cam_fb_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .p_clock(p_clock), .rst(rst), .arm(arm), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .frame_done(frame_done), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .overflow(overflow), .pix_count(pix_count)
`ifdef CAM_FB_DOUBLE_BUF_EN
    , .fb_bank(fb_bank)
`endif
  );

  always #5 p_clock = ~p_clock;

  int vectors = 0, miscompares = 0;

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  wr_t wr_q[$];
  wr_t exp_q[$];

  always @(negedge p_clock) if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});

  // Frame-level reference state
  int m_mode = M_IDLE;
  int m_cnt  = 0;
  bit m_ovf  = 1'b0;
  bit m_bank = 1'b0;

  function automatic logic [7:0] rgb332(input logic [23:0] d);
    return {d[7:5], d[15:13], d[23:22]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic a, input logic v, input logic [23:0] d, input logic f);
    arm = a; pixel_valid = v; pixel_data = d; frame_done = f;
    @(negedge p_clock);
  endtask

  task automatic do_arm();
    step(1'b1, 1'b0, 24'h0, 1'b0);
    if (m_mode == M_IDLE || m_mode == M_DONE) begin
      m_mode = M_ARMED; m_cnt = 0; m_ovf = 1'b0;
    end
  endtask

  // Sends n pixels with random gaps, then a frame_done pulse (optionally on the last pixel).
  task automatic send_frame(input int n, input bit coin, input bit gaps);
    int base;
    logic [23:0] d;
    base = (DB && !m_bank) ? FRAME : 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 24'($urandom), 1'b0);
      d = 24'($urandom);
      step(1'b0, 1'b1, d, (coin && i == n - 1));
      if (m_mode == M_CAP && i < FRAME) exp_q.push_back({AW'(base + i), rgb332(d)});
    end
    if (!coin || n == 0) step(1'b0, 1'b0, 24'h0, 1'b1);
    step(1'b0, 1'b0, 24'h0, 1'b0);
    if (m_mode == M_CAP) begin
      m_cnt  = (n < FRAME) ? n : FRAME;
      m_ovf  = (n > FRAME);
      m_mode = M_DONE;
      if (DB && m_cnt == FRAME) m_bank = ~m_bank;
    end else if (m_mode == M_ARMED) begin
      m_mode = M_CAP;
    end
  endtask

  task automatic check_all(input string tag);
    step(1'b0, 1'b0, 24'h0, 1'b0);
    #1;
    chk({tag, "_busy"}, busy, (m_mode == M_ARMED || m_mode == M_CAP));
    chk({tag, "_done"}, done, (m_mode == M_DONE));
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_cnt"}, pix_count, m_cnt);
`ifdef CAM_FB_DOUBLE_BUF_EN
    chk({tag, "_bank"}, fb_bank, m_bank);
`endif
    chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic a, v; logic [23:0] d; logic f;
    logic we; int addr; logic [7:0] wd; logic bsy, dn; int cnt;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int off;
    int n;
    bit coin;
    off = DB ? FRAME : 0;
    // inputs / outputs after the edge that samples them
    tbl[0] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 24'hC0A0E0, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b1, 24'hC0A0E0, 1'b0, 1'b1, 0, 8'hF7, 1'b1, 1'b0, 1};
    tbl[4] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1};
    tbl[5] = '{1'b0, 1'b1, 24'h123456, 1'b0, 1'b1, 1, 8'h44, 1'b1, 1'b0, 2};
    tbl[6] = '{1'b0, 1'b1, 24'hFFFFFF, 1'b1, 1'b1, 2, 8'hFF, 1'b0, 1'b1, 3};
    tbl[7] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 3};
    tbl[8] = '{1'b1, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0};
    tbl[9] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0};

    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, 24'h0, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_cnt", pix_count, '0);
    chk("rst_bank", fb_bank, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].a, tbl[i].v, tbl[i].d, tbl[i].f);
      chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_addr", i), mem_addr, AW'(tbl[i].addr + off));
        chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].wd);
      end
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
      chk($sformatf("tbl%0d_cnt", i), pix_count, tbl[i].cnt);
    end

    // Reset mid-capture, with ignored arm pulses and a write still in flight.
    step(1'b0, 1'b0, 24'h0, 1'b1);
    step(1'b0, 1'b0, 24'h0, 1'b0);
    wr_q.delete();
    repeat (3) step(1'b0, 1'b1, 24'($urandom), 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    chk("armcap_busy", busy, 1'b1);
    chk("armcap_cnt", pix_count, 3);
    step(1'b0, 1'b1, 24'($urandom), 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 24'($urandom), 1'b0);
    rst = 1'b0;
    chk("midrst_we", mem_we, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_cnt", pix_count, 0);
    step(1'b0, 1'b1, 24'($urandom), 1'b0);
    chk("midrst_idle_we", mem_we, 1'b0);
    chk("midrst_nwr", wr_q.size(), 4);
    wr_q.delete();
    m_mode = M_IDLE; m_cnt = 0; m_ovf = 1'b0; m_bank = 1'b0;

    do_arm(); send_frame(8, 1'b0, 1'b0); check_all("full_a");
    send_frame(8, 1'b0, 1'b1);           check_all("full_b");
    do_arm(); send_frame(10, 1'b0, 1'b0); send_frame(10, 1'b0, 1'b1); check_all("ovf");
    do_arm(); send_frame(3, 1'b0, 1'b0); send_frame(5, 1'b0, 1'b0);   check_all("short");
    do_arm(); send_frame(8, 1'b1, 1'b0); check_all("coin_armed");
    send_frame(8, 1'b0, 1'b0);           check_all("after_short");
    do_arm(); send_frame(2, 1'b0, 1'b0); send_frame(4, 1'b1, 1'b0);   check_all("coin_cap");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) != 0) do_arm();
      n    = $urandom_range(0, 11);
      coin = 1'($urandom_range(0, 1));
      send_frame(n, coin, 1'b1);
      check_all($sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
